// File: rtl/bcd_hex_display_pkg.sv
// Shared constants for the BCD hex display stage:
// segment codes, FSM encoding and digit geometry.
package display_pkg;

  localparam int NDIG = 6;
  localparam int DIGW = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

  localparam logic [1:0] ST_SHOW = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;

endpackage

// File: rtl/bcd_hex_display_if.sv
// Display bus: BCD capture inputs and HEX/status outputs.
// master = BCD source side, slave = display stage.
interface bcd_hex_display_if;
  import display_pkg::*;

  logic [25:0] bcd_in;
  logic        bcd_valid;
  logic        blank_lz;
  seg_t        hex0;
  seg_t        hex1;
  seg_t        hex2;
  seg_t        hex3;
  seg_t        hex4;
  seg_t        hex5;
  logic        ovf;
  logic        busy;

  modport master (
    output bcd_in, bcd_valid, blank_lz,
    input  hex0, hex1, hex2, hex3, hex4, hex5,
    input  ovf, busy
  );

  modport slave (
    input  bcd_in, bcd_valid, blank_lz,
    output hex0, hex1, hex2, hex3, hex4, hex5,
    output ovf, busy
  );
endinterface

// File: rtl/bcd_hex_display_bcd7seg.sv
// Single-digit BCD to active-low 7-segment decoder.
// digit_i: 4-bit code; seg_o: segments a..g, 10..15 -> dash.
module bcd7seg
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_hex_display.sv
// Holds captured BCD word, drives six HEX displays with
// blanking/saturation, flashes after a changed load.
// Ports: clk, rst (async high), bus (slave modport).
module bcd_hex_display
  import display_pkg::*;
#(
  parameter int BLINK_DIV   = 12_500_000,
  parameter int FLASH_COUNT = 3
) (
  input logic              clk,
  input logic              rst,
  bcd_hex_display_if.slave bus
);

  localparam int DW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CW =
    (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL =
    CW'(FLASH_COUNT);
  localparam bit FLASH_EN = (FLASH_COUNT > 0);

  logic [25:0]   val_q, val_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          ovf_q;
  seg_t          hex_q [NDIG];
  seg_t          hex_d [NDIG];

  seg_t            raw [NDIG];
  logic [NDIG-1:0] lead;
  logic            seen;
  logic            ovf_now;
  logic            changed;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd7seg u_seg (
      .digit_i (val_q[g*DIGW +: DIGW]),
      .seg_o   (raw[g])
    );
  end

  assign ovf_now = |val_q[25:24];

  // lead[k]: digit k and everything above it is zero
  always_comb begin
    seen = 1'b0;
    lead = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      seen    = seen | (val_q[k*DIGW +: DIGW] != '0);
      lead[k] = ~seen;
    end
  end

  always_comb begin
    for (int k = 0; k < NDIG; k++) begin
      if (state_q == ST_OFF)
        hex_d[k] = SEG_OFF;
      else if (ovf_now)
        hex_d[k] = SEG_9;
      else if (bus.blank_lz && k != 0 && lead[k])
        hex_d[k] = SEG_OFF;
      else
        hex_d[k] = raw[k];
    end
  end

  assign changed = bus.bcd_valid &&
                   (bus.bcd_in != val_q);

  always_comb begin
    val_d   = val_q;
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (bus.bcd_valid)
      val_d = bus.bcd_in;
    // a changed load always restarts the sequence
    if (changed && FLASH_EN) begin
      state_d = ST_OFF;
      div_d   = '0;
      cnt_d   = CNT_FULL;
    end else begin
      unique case (state_q)
        ST_SHOW: ;
        ST_OFF: begin
          if (div_q == DIV_LAST) begin
            state_d = ST_ON;
            div_d   = '0;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        ST_ON: begin
          if (div_q == DIV_LAST) begin
            cnt_d   = cnt_q - CW'(1);
            div_d   = '0;
            state_d = (cnt_q == CW'(1)) ?
                      ST_SHOW : ST_OFF;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: state_d = ST_SHOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      state_q <= ST_SHOW;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= '{default: SEG_OFF};
    end else begin
      val_q   <= val_d;
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_SHOW);
      ovf_q   <= ovf_now;
      hex_q   <= hex_d;
    end
  end

  assign bus.hex0 = hex_q[0];
  assign bus.hex1 = hex_q[1];
  assign bus.hex2 = hex_q[2];
  assign bus.hex3 = hex_q[3];
  assign bus.hex4 = hex_q[4];
  assign bus.hex5 = hex_q[5];
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_bcd_hex_display.sv
// Directed bench for bcd_hex_display with an
// expected-value queue popped at each sample point.
module tb_bcd_hex_display;

  localparam logic [6:0] H0   = 7'h40;
  localparam logic [6:0] H1   = 7'h79;
  localparam logic [6:0] H2   = 7'h24;
  localparam logic [6:0] H3   = 7'h30;
  localparam logic [6:0] H4   = 7'h19;
  localparam logic [6:0] H5   = 7'h12;
  localparam logic [6:0] H7   = 7'h78;
  localparam logic [6:0] H9   = 7'h10;
  localparam logic [6:0] HDSH = 7'h3F;
  localparam logic [6:0] HOFF = 7'h7F;

  typedef struct {
    string       tag;
    logic [41:0] hex;
    logic        ovf;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  bcd_hex_display_if ifa ();
  bcd_hex_display_if ifb ();

  bcd_hex_display #(
    .BLINK_DIV   (4),
    .FLASH_COUNT (2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  bcd_hex_display #(
    .BLINK_DIV   (4),
    .FLASH_COUNT (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  function automatic logic [41:0] hexa();
    return {ifa.hex5, ifa.hex4, ifa.hex3,
            ifa.hex2, ifa.hex1, ifa.hex0};
  endfunction

  function automatic logic [41:0] hexb();
    return {ifb.hex5, ifb.hex4, ifb.hex3,
            ifb.hex2, ifb.hex1, ifb.hex0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t,
                      input logic [41:0] h,
                      input logic o,
                      input logic b);
    exp_t e;
    e.tag  = t;
    e.hex  = h;
    e.ovf  = o;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic check(input logic [41:0] h,
                       input logic o,
                       input logic b);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty act=%0d req=1",
             sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (h === e.hex) else begin
        errors++;
        $error("FAIL %s hex act=%h req=%h",
               e.tag, h, e.hex);
      end
      checks++;
      assert (o === e.ovf) else begin
        errors++;
        $error("FAIL %s ovf act=%b req=%b",
               e.tag, o, e.ovf);
      end
      checks++;
      assert (b === e.busy) else begin
        errors++;
        $error("FAIL %s busy act=%b req=%b",
               e.tag, b, e.busy);
      end
    end
  endtask

  task automatic chk_a();
    check(hexa(), ifa.ovf, ifa.busy);
  endtask

  // i counts edges after the load strobe edge
  task automatic flash_seq(input string t,
                           input logic [41:0] on_pat,
                           input logic o,
                           input int from,
                           input int to);
    logic off;
    for (int i = from; i <= to; i++) begin
      step();
      off = (i >= 1 && i <= 4) ||
            (i >= 9 && i <= 12);
      push(t, off ? {6{HOFF}} : on_pat,
           o, (i < 16));
      chk_a();
    end
  endtask

  initial begin
    ifa.bcd_in    = '0;
    ifa.bcd_valid = 1'b0;
    ifa.blank_lz  = 1'b0;
    ifb.bcd_in    = '0;
    ifb.bcd_valid = 1'b0;
    ifb.blank_lz  = 1'b1;

    #2 rst = 1'b1;
    step();
    step();
    push("rst", {6{HOFF}}, 1'b0, 1'b0);
    chk_a();
    rst = 1'b0;
    step();
    push("rel_nolz", {6{H0}}, 1'b0, 1'b0);
    chk_a();
    ifa.blank_lz = 1'b1;
    step();
    push("rel_lz", {{5{HOFF}}, H0}, 1'b0, 1'b0);
    chk_a();

    ifa.bcd_in    = 26'h0000007;
    ifa.bcd_valid = 1'b1;
    push("fl_n", {{5{HOFF}}, H0}, 1'b0, 1'b1);
    step();
    ifa.bcd_valid = 1'b0;
    chk_a();
    flash_seq("fl7", {{5{HOFF}}, H7}, 1'b0, 1, 17);

    ifa.blank_lz  = 1'b0;
    ifa.bcd_in    = 26'h00000A3;
    ifa.bcd_valid = 1'b1;
    push("inv_n", {{5{H0}}, H7}, 1'b0, 1'b1);
    step();
    ifa.bcd_valid = 1'b0;
    chk_a();
    flash_seq("inv", {{4{H0}}, HDSH, H3},
              1'b0, 1, 5);
    ifa.bcd_valid = 1'b1;
    flash_seq("same", {{4{H0}}, HDSH, H3},
              1'b0, 6, 6);
    ifa.bcd_valid = 1'b0;
    flash_seq("same", {{4{H0}}, HDSH, H3},
              1'b0, 7, 10);
    ifa.bcd_in    = 26'h0000005;
    ifa.bcd_valid = 1'b1;
    push("rs_n", {6{HOFF}}, 1'b0, 1'b1);
    step();
    ifa.bcd_valid = 1'b0;
    chk_a();
    flash_seq("rst5", {{5{H0}}, H5}, 1'b0, 1, 17);

    ifa.bcd_in    = 26'h1000000;
    ifa.bcd_valid = 1'b1;
    push("ov_n", {{5{H0}}, H5}, 1'b0, 1'b1);
    step();
    ifa.bcd_valid = 1'b0;
    chk_a();
    flash_seq("ovf", {6{H9}}, 1'b1, 1, 17);
    ifa.bcd_in    = 26'h0999999;
    ifa.bcd_valid = 1'b1;
    push("nov_n", {6{H9}}, 1'b1, 1'b1);
    step();
    ifa.bcd_valid = 1'b0;
    chk_a();
    flash_seq("nov", {6{H9}}, 1'b0, 1, 17);

    ifb.bcd_in    = 26'h0012345;
    ifb.bcd_valid = 1'b1;
    push("b_n", {{5{HOFF}}, H0}, 1'b0, 1'b0);
    step();
    ifb.bcd_valid = 1'b0;
    check(hexb(), ifb.ovf, ifb.busy);
    step();
    push("b_val", {HOFF, H1, H2, H3, H4, H5},
         1'b0, 1'b0);
    check(hexb(), ifb.ovf, ifb.busy);

    ifa.bcd_in    = 26'h0000042;
    ifa.bcd_valid = 1'b1;
    step();
    ifa.bcd_valid = 1'b0;
    step();
    step();
    push("mid_off", {6{HOFF}}, 1'b0, 1'b1);
    chk_a();
    #2 rst = 1'b1;
    #1;
    push("async", {6{HOFF}}, 1'b0, 1'b0);
    chk_a();
    step();
    rst = 1'b0;
    step();
    push("post", {6{H0}}, 1'b0, 1'b0);
    chk_a();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
